// File: rtl/phy_link_pkg.sv
// phy_link_pkg: shared types and constants for the GT RX link controller.
// Holds state encodings, the K28.5 comma symbol and default parameters.
package phy_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET      = 3'd1,
    ST_WAIT_DONE  = 3'd2,
    ST_WAIT_ALIGN = 3'd3,
    ST_TRAIN      = 3'd4,
    ST_UP         = 3'd5
  } link_state_e;

  localparam logic [7:0] K28_5 = 8'hBC;

  localparam int unsigned DEF_RST_CYCLES   = 16;
  localparam int unsigned DEF_ALIGN_WORDS  = 64;
  localparam int unsigned DEF_LOS_TIMEOUT  = 1024;
  localparam int unsigned DEF_INIT_TIMEOUT = 65535;

  // A word carries a comma when any lane holds K28.5 flagged as K-char.
  function automatic logic comma_word(
    input logic [31:0] d,
    input logic [3:0]  k
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hit = hit | (k[i] & (d[8*i +: 8] == K28_5));
    end
    return hit;
  endfunction

endpackage

// File: rtl/phy_link_ctrl_comma_det.sv
// phy_comma_det: registers a 4-lane RX word and flags K28.5 commas.
// Ports: i_clk, i_rst (async, high), rx_data[31:0], rx_charisk[3:0],
//        comma_q (comma seen in the word registered on the last edge).
module phy_comma_det
  import phy_link_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_charisk,
  output logic        comma_q
);

  logic [31:0] data_q;
  logic [3:0]  isk_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q <= '0;
      isk_q  <= '0;
    end else begin
      data_q <= rx_data;
      isk_q  <= rx_charisk;
    end
  end

  assign comma_q = comma_word(data_q, isk_q);

endmodule

// File: rtl/phy_link_ctrl.sv
// phy_link_ctrl: GT RX bring-up, qualification and supervision FSM.
// Ports: i_clk, i_rst (async, high), i_gt_pll_lock, i_gt_rst_done,
//        i_gt_bytealign, i_gt_rx_data[31:0], i_gt_rx_charisk[3:0],
//        o_gt_rx_reset, o_rx_en, o_link_up, o_state[2:0],
//        o_link_drop_cnt[15:0] (live only with PHY_LINK_STATS_EN).
module phy_link_ctrl
  import phy_link_pkg::*;
#(
  parameter int unsigned P_RST_CYCLES   = DEF_RST_CYCLES,
  parameter int unsigned P_ALIGN_WORDS  = DEF_ALIGN_WORDS,
  parameter int unsigned P_LOS_TIMEOUT  = DEF_LOS_TIMEOUT,
  parameter int unsigned P_INIT_TIMEOUT = DEF_INIT_TIMEOUT
)(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_gt_pll_lock,
  input  logic        i_gt_rst_done,
  input  logic        i_gt_bytealign,
  input  logic [31:0] i_gt_rx_data,
  input  logic [3:0]  i_gt_rx_charisk,
  output logic        o_gt_rx_reset,
  output logic        o_rx_en,
  output logic        o_link_up,
  output logic [2:0]  o_state,
  output logic [15:0] o_link_drop_cnt
);

  localparam int unsigned RW = $clog2(P_RST_CYCLES + 1);
  localparam int unsigned AW = $clog2(P_ALIGN_WORDS + 1);
  localparam int unsigned LW = $clog2(P_LOS_TIMEOUT + 1);
  localparam int unsigned TW = $clog2(P_INIT_TIMEOUT + 1);

  localparam logic [RW-1:0] RST_END = RW'(P_RST_CYCLES);
  localparam logic [AW-1:0] ALN_END = AW'(P_ALIGN_WORDS);
  localparam logic [LW-1:0] LOS_END = LW'(P_LOS_TIMEOUT);
  localparam logic [TW-1:0] TMO_END = TW'(P_INIT_TIMEOUT);

  link_state_e state_q, state_d;

  logic          comma_q;
  logic [RW-1:0] rst_q, rst_d;
  logic [AW-1:0] word_q, word_d;
  logic [LW-1:0] los_q, los_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  logic          init_st;

  phy_comma_det u_comma_det (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .rx_data    (i_gt_rx_data),
    .rx_charisk (i_gt_rx_charisk),
    .comma_q    (comma_q)
  );

  // Next counter values; all saturate at their end value.
  assign rst_d = (rst_q == RST_END) ? rst_q
               : rst_q + RW'(1);
  assign tmo_d = (tmo_q == TMO_END) ? tmo_q
               : tmo_q + TW'(1);

  always_comb begin
    word_d = '0;
    if (comma_q) begin
      word_d = (word_q == ALN_END) ? word_q
             : word_q + AW'(1);
    end
  end

  always_comb begin
    los_d = '0;
    if (!comma_q) begin
      los_d = (los_q == LOS_END) ? los_q
            : los_q + LW'(1);
    end
  end

  assign tmo_hit = (tmo_q == TMO_END);
  assign init_st = (state_q == ST_WAIT_DONE)
                 | (state_q == ST_WAIT_ALIGN)
                 | (state_q == ST_TRAIN);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock loss beats everything; retry conditions beat advancing.
  always_comb begin
    state_d = state_q;
    if (state_q != ST_IDLE && !i_gt_pll_lock) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_gt_pll_lock) state_d = ST_RESET;
        end
        ST_RESET: begin
          if (rst_d == RST_END) state_d = ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (tmo_hit)            state_d = ST_RESET;
          else if (i_gt_rst_done) state_d = ST_WAIT_ALIGN;
        end
        ST_WAIT_ALIGN: begin
          if (tmo_hit)             state_d = ST_RESET;
          else if (i_gt_bytealign) state_d = ST_TRAIN;
        end
        ST_TRAIN: begin
          if (!i_gt_bytealign || tmo_hit)
            state_d = ST_RESET;
          else if (word_d == ALN_END)
            state_d = ST_UP;
        end
        ST_UP: begin
          if (los_d == LOS_END || !i_gt_bytealign
              || !i_gt_rst_done)
            state_d = ST_RESET;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Each counter runs only while its state persists, so it reads 0
  // on the first cycle of every state entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rst_q  <= '0;
      word_q <= '0;
      los_q  <= '0;
      tmo_q  <= '0;
    end else begin
      rst_q  <= (state_q == ST_RESET && state_d == ST_RESET)
              ? rst_d : '0;
      word_q <= (state_q == ST_TRAIN && state_d == ST_TRAIN)
              ? word_d : '0;
      los_q  <= (state_q == ST_UP && state_d == ST_UP)
              ? los_d : '0;
      tmo_q  <= (init_st && state_d == state_q)
              ? tmo_d : '0;
    end
  end

  // Outputs decode the next state so they flip with the state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_gt_rx_reset <= 1'b0;
      o_rx_en       <= 1'b0;
      o_link_up     <= 1'b0;
    end else begin
      o_gt_rx_reset <= (state_d == ST_RESET);
      o_rx_en       <= (state_d == ST_UP);
      o_link_up     <= (state_d == ST_UP);
    end
  end

  assign o_state = state_q;

`ifdef PHY_LINK_STATS_EN
  logic [15:0] drop_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      drop_q <= '0;
    end else if (state_q == ST_UP && state_d != ST_UP
                 && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign o_link_drop_cnt = drop_q;
`else
  assign o_link_drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_phy_link_ctrl.sv
// tb_phy_link_ctrl: directed plus random checks of phy_link_ctrl
// against a timestamp-based reference model.
module tb_phy_link_ctrl;

  localparam int RSTC = 4;
  localparam int ALW  = 8;
  localparam int LOS  = 16;
  localparam int TMO  = 32;
`ifdef PHY_LINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lock = 1'b0;
  logic        done = 1'b0;
  logic        align = 1'b0;
  logic [31:0] data = '0;
  logic [3:0]  isk = '0;
  logic        o_gt_rx_reset;
  logic        o_rx_en;
  logic        o_link_up;
  logic [2:0]  o_state;
  logic [15:0] o_link_drop_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int m_st, m_ent, m_lc, m_lnc, m_drops;
  bit cq_pipe;
  int lat, hi;
  int ent[$];
  logic [2:0] prev;

  always #5 clk = ~clk;

  phy_link_ctrl #(
    .P_RST_CYCLES   (RSTC),
    .P_ALIGN_WORDS  (ALW),
    .P_LOS_TIMEOUT  (LOS),
    .P_INIT_TIMEOUT (TMO)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_gt_pll_lock   (lock),
    .i_gt_rst_done   (done),
    .i_gt_bytealign  (align),
    .i_gt_rx_data    (data),
    .i_gt_rx_charisk (isk),
    .o_gt_rx_reset   (o_gt_rx_reset),
    .o_rx_en         (o_rx_en),
    .o_link_up       (o_link_up),
    .o_state         (o_state),
    .o_link_drop_cnt (o_link_drop_cnt)
  );

  function automatic bit is_comma(logic [31:0] d, logic [3:0] k);
    bit hit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (k[i] && d[8*i +: 8] == 8'hBC) hit = 1'b1;
    return hit;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_ent = cyc; m_lc = cyc; m_lnc = cyc;
    m_drops = 0; cq_pipe = 1'b0;
  endtask

  // Model uses time-in-state and time since the last (non-)comma
  // instead of explicit counters.
  task automatic model_step(input bit lk, input bit dn,
                            input bit al, input bit cq);
    int nxt, spent, run, quiet;
    spent = cyc - m_ent;
    run   = cq ? cyc - imax(m_ent, m_lnc) : 0;
    quiet = cq ? 0 : cyc - imax(m_ent, m_lc);
    if (cq) m_lc = cyc; else m_lnc = cyc;
    nxt = m_st;
    if (m_st != 0 && !lk) nxt = 0;
    else case (m_st)
      0: if (lk) nxt = 1;
      1: if (spent == RSTC) nxt = 2;
      2: if (spent > TMO) nxt = 1; else if (dn) nxt = 3;
      3: if (spent > TMO) nxt = 1; else if (al) nxt = 4;
      4: if (!al || spent > TMO) nxt = 1;
         else if (run == ALW) nxt = 5;
      5: if (quiet == LOS || !al || !dn) nxt = 1;
      default: nxt = 0;
    endcase
    if (nxt != m_st) begin
      if (m_st == 5 && STATS && m_drops < 65535) m_drops++;
      m_ent = cyc;
    end
    m_st = nxt;
  endtask

  task automatic check_model();
    chk("state", 32'(o_state), m_st);
    chk("gt_rx_reset", 32'(o_gt_rx_reset), 32'(m_st == 1));
    chk("link_up", 32'(o_link_up), 32'(m_st == 5));
    chk("rx_en", 32'(o_rx_en), 32'(m_st == 5));
    chk("drop_cnt", 32'(o_link_drop_cnt), m_drops);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else begin
      model_step(lock, done, align, cq_pipe);
      cq_pipe = is_comma(data, isk);
    end
    #1;
    check_model();
  endtask

  task automatic comma_in();
    data = 32'h50BC50BC; isk = 4'b0101;
  endtask

  task automatic bring_up(output int l, output int h);
    int c0;
    lock = 1'b0; done = 1'b1; align = 1'b1; comma_in();
    tick();
    lock = 1'b1; c0 = cyc; l = -1; h = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (o_gt_rx_reset) h++;
      if (o_link_up) begin l = cyc - c0; break; end
    end
  endtask

  task automatic go_train();
    lock = 1'b0; tick();
    lock = 1'b1; done = 1'b1; align = 1'b0;
    data = '0; isk = '0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_state == 3'd3) break;
    end
    chk("reach_wait_align", 32'(o_state), 3);
    align = 1'b1;
  endtask

  task automatic rand_word(input bit want);
    int ln;
    data = $urandom; isk = 4'($urandom);
    ln = $urandom_range(0, 3);
    data[8*ln +: 8] = 8'hBC;
    isk[ln] = want;
  endtask

  initial begin
    model_reset();
    #2;
    check_model();
    tick(); tick();
    rst = 1'b0;

    bring_up(lat, hi);
    chk("bringup_latency", lat, 15);
    chk("rst_pulse_len", hi, 4);
    chk("bringup_rx_en", 32'(o_rx_en), 1);

    // BC bytes without K flag are not commas.
    data = 32'h50BC50BC; isk = 4'b0000;
    for (int k = 0; k < LOS; k++) begin
      tick();
      chk("los_hold", 32'(o_link_up), 1);
    end
    tick();
    chk("los_drop_state", 32'(o_state), 1);
    chk("los_drop_cnt", 32'(o_link_drop_cnt), 32'(STATS));

    comma_in();
    for (int k = 0; k < 60; k++) begin
      tick();
      if (o_link_up) break;
    end
    chk("reup", 32'(o_link_up), 1);

    isk = 4'b0000;
    for (int k = 0; k < LOS - 1; k++) tick();
    comma_in();
    for (int k = 0; k < 20; k++) tick();
    chk("los_no_drop", 32'(o_state), 5);

    lock = 1'b0;
    tick();
    chk("lockloss_up_state", 32'(o_state), 0);
    chk("lockloss_up_rx_en", 32'(o_rx_en), 0);
    chk("lockloss_drop_cnt", 32'(o_link_drop_cnt),
        STATS ? 32'd2 : 32'd0);

    go_train();
    for (int i = 0; i < 14; i++) begin
      if (i == 5) begin data = '0; isk = '0; end
      else comma_in();
      tick();
      chk("train_break_wait", 32'(o_link_up), 0);
    end
    comma_in();
    tick();
    chk("train_break_up", 32'(o_link_up), 1);

    go_train();
    comma_in();
    tick(); tick(); tick();
    chk("in_train", 32'(o_state), 4);
    lock = 1'b0;
    tick();
    chk("lockloss_train", 32'(o_state), 0);
    chk("lockloss_train_en", 32'(o_rx_en), 0);

    go_train();
    comma_in();
    for (int k = 0; k < ALW; k++) tick();
    chk("simul_pre", 32'(o_state), 4);
    align = 1'b0;
    tick();
    chk("simul_state", 32'(o_state), 1);
    chk("simul_up", 32'(o_link_up), 0);

    lock = 1'b0; tick();
    done = 1'b0; lock = 1'b1; align = 1'b1;
    prev = o_state;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (o_state == 3'd1 && prev != 3'd1) ent.push_back(cyc);
      prev = o_state;
    end
    chk("tmo_entries", ent.size(), 3);
    if (ent.size() >= 3) begin
      chk("tmo_period_a", ent[1] - ent[0], 37);
      chk("tmo_period_b", ent[2] - ent[1], 37);
    end

    for (int n = 0; n < 3000; n++) begin
      lock  = ($urandom_range(0, 199) != 0);
      done  = ($urandom_range(0, 59) != 0);
      align = ($urandom_range(0, 59) != 0);
      rand_word($urandom_range(0, 9) != 0);
      tick();
    end

    bring_up(lat, hi);
    chk("pre_rst_up", 32'(o_link_up), 1);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_state", 32'(o_state), 0);
    chk("arst_up", 32'(o_link_up), 0);
    chk("arst_rx_en", 32'(o_rx_en), 0);
    chk("arst_gt_rst", 32'(o_gt_rx_reset), 0);
    chk("arst_drops", 32'(o_link_drop_cnt), 0);
    tick();
    rst = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phy_link_ctrl.md
# phy_link_ctrl

Link bring-up and supervision controller for the GT PHY receive path. It sequences the GT receiver reset after PLL lock, then waits for reset-done and byte alignment. It qualifies the link by counting comma-bearing words before enabling the downstream RX framer. Once up, it monitors the link for loss of commas, alignment or lock, and re-initialises automatically.

## Interface
- P_RST_CYCLES, 16: cycles `o_gt_rx_reset` is held high per reset attempt (≥1).
- P_ALIGN_WORDS, 64: consecutive comma-bearing words required to declare link up (≥1).
- P_LOS_TIMEOUT, 1024: cycles without any comma word in UP before the link is dropped (≥2).
- P_INIT_TIMEOUT, 65535: maximum cycles spent in each of WAIT_DONE, WAIT_ALIGN and TRAIN before retrying reset.
- i_clk  in  1  clock; all logic is single-domain.
- i_rst  in  1  reset, asynchronous, active-high.
- i_gt_pll_lock  in  1  GT PLL locked.
- i_gt_rst_done  in  1  GT RX reset complete.
- i_gt_bytealign  in  1  GT comma byte alignment achieved.
- i_gt_rx_data  in  32  GT RX data; byte lane k is bits [8k+7:8k].
- i_gt_rx_charisk  in  4  K-character flag per byte lane.
- o_gt_rx_reset  out  1  GT RX reset request.
- o_rx_en  out  1  enable for the RX framer; the framer flushes when low.
- o_link_up  out  1  link qualified.
- o_state  out  3  current state encoding, for debug.
- o_link_drop_cnt  out  16  link-drop statistic; see Configuration.

## Operation
- Comma word: a word is a comma word if any lane k has data byte 8'hBC (K28.5) with charisk[k]=1. Inputs are registered once before detection, so `comma_q` lags the port by 1 cycle.
- States and encodings: IDLE=0, RESET=1, WAIT_DONE=2, WAIT_ALIGN=3, TRAIN=4, UP=5.
- Global rule: if `i_gt_pll_lock`=0 in any state other than IDLE, the next state is IDLE. This rule has highest priority.
- IDLE: `o_gt_rx_reset`=0. Go to RESET on `i_gt_pll_lock`=1.
- RESET: `o_gt_rx_reset`=1. A cycle counter starts at 0. After exactly P_RST_CYCLES cycles in RESET, go to WAIT_DONE.
- WAIT_DONE: go to WAIT_ALIGN on `i_gt_rst_done`=1.
- WAIT_ALIGN: go to TRAIN on `i_gt_bytealign`=1.
- TRAIN: the word counter increments on `comma_q`=1 and clears to 0 on `comma_q`=0. When it reaches P_ALIGN_WORDS, go to UP. If `i_gt_bytealign`=0, go to RESET.
- UP: the LOS counter clears on `comma_q`=1 and otherwise increments. Go to RESET when the counter reaches P_LOS_TIMEOUT, or when `i_gt_bytealign`=0 or `i_gt_rst_done`=0.
- Timeout: WAIT_DONE, WAIT_ALIGN and TRAIN share one timeout counter, cleared on every state entry. When it reaches P_INIT_TIMEOUT, go to RESET.
- Counter widths: `$clog2`(parameter+1). Counters saturate and never wrap.
- Simultaneous events: a drop/retry condition (bytealign low, timeout) wins over the advance condition in the same cycle, so TRAIN reaching P_ALIGN_WORDS while bytealign=0 goes to RESET.

## Timing
- Reset values: state=IDLE, all counters 0.
  - `o_gt_rx_reset`=0, `o_rx_en`=0, `o_link_up`=0.
  - `o_state`=0, `o_link_drop_cnt`=0.
- All outputs are registered, Moore-decoded from the state register. They change on the cycle the state changes.
  - `o_gt_rx_reset`=1 only in RESET.
  - `o_link_up`=`o_rx_en`=1 only in UP.
- Comma word at the input port to TRAIN counter update: 2 cycles (input register + counter register).
- Minimum bring-up with all status inputs already high: IDLE→RESET at 1 cycle, then P_RST_CYCLES cycles in RESET, then 1 cycle each in WAIT_DONE and WAIT_ALIGN, then P_ALIGN_WORDS cycles in TRAIN.
- Leaving UP: `o_rx_en` falls the same cycle as `o_link_up`, including mid-frame. The framer discards any partial frame.
- An asynchronous `i_rst` asserted mid-operation immediately forces the reset values listed above.

## Configuration
- PHY_LINK_STATS_EN defined:
  - `o_link_drop_cnt` increments on every UP→non-UP transition.
  - It saturates at 16'hFFFF and clears only on `i_rst`.
- PHY_LINK_STATS_EN undefined: no counter is built and `o_link_drop_cnt` is tied to 0. The port is always present.

## Structure
- Package `phy_link_pkg` holds:
  - state encoding constants;
  - K28_5 = 8'hBC;
  - default parameter values.
- Sub-module `phy_comma_det`: the input register plus 4-lane comma compare, producing `comma_q`. It is reusable on the TX loopback check.
- The FSM and counters live in the `phy_link_ctrl` top.

## Test plan
- Bring-up, with P_RST_CYCLES=4, P_ALIGN_WORDS=8, data=32'h50BC50BC, charisk=4'b0101, all status inputs high → `o_gt_rx_reset` high exactly 4 cycles; `o_link_up` rises 15 cycles after lock.
- Training break: 5 comma words, 1 word with data=32'h00000000 and charisk=0, then 8 comma words → link up only after the final 8-word run.
- LOS, with P_LOS_TIMEOUT=16: in UP, drive non-comma data for 16 cycles → link drops to RESET and `o_link_drop_cnt`=1 (STATS_EN); no drop if a comma word arrives at cycle 15.
- Lock loss: `i_gt_pll_lock`=0 in TRAIN or UP → next state IDLE and `o_rx_en`=0; relock → full sequence repeats.
- Init timeout: `i_gt_rst_done` held low with P_INIT_TIMEOUT=32 → RESET re-entered every 4+1+32 cycles.
- Simultaneous/reset: bytealign drops on the same cycle the TRAIN count hits 8 → RESET, not UP; assert `i_rst` while in UP → all outputs 0 immediately.
